lc3_boot_ctrl: RTL and testbench

- Owns the LC-3 core's unified program/data memory and sequences the core through load, run and halt.
- While a host streams a program into memory over a valid/ready port, the core is held in reset.
- On start, the core is released and its cycles are counted. The core is stopped when it fetches the halt vector or a cycle budget expires.
- Sits between the testbench/host and the LC-3 core's mar/mdr/memwe/memOut memory interface.

---
 rtl/lc3_boot_ctrl.sv | 121 ++++++++++++
 tb/tb_lc3_boot_ctrl.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/lc3_boot_ctrl.sv
// LC-3 boot controller: owns the core's unified 16-bit memory, accepts a program
// image from a host while the core is held in reset, then runs the core until halt or timeout.
module lc3_boot_ctrl #(
    parameter int unsigned AW         = 8,
    parameter logic [15:0] HALT_ADDR  = 16'h0025,
    parameter logic [31:0] MAX_CYCLES = 32'd10000
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          ld_valid,
    output logic          ld_ready,
    input  logic [AW-1:0] ld_addr,
    input  logic [15:0]   ld_data,
    input  logic          ld_last,
    input  logic          start,
    input  logic          clear,
    output logic          cpu_reset,
    input  logic [15:0]   cpu_mar,
    input  logic [15:0]   cpu_mdr,
    input  logic          cpu_memwe,
    output logic [15:0]   cpu_mem_out,
    input  logic [AW-1:0] rd_addr,
    output logic [15:0]   rd_data,
    output logic [1:0]    state_o,
    output logic          loaded,
    output logic          halted,
    output logic          timed_out,
    output logic [31:0]   cycle_count
);

    localparam int unsigned DEPTH = 2 ** AW;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_HALT = 2'd2;

    logic [1:0]  state;
    logic [1:0]  next_state;
    logic [15:0] mem [DEPTH];

    logic ld_fire;
    logic hit_halt;
    logic hit_budget;
    logic run_entry;
    logic halt_clear;

    assign ld_ready    = (state == S_IDLE);
    assign ld_fire     = ld_ready && ld_valid;
    assign hit_halt    = (cpu_mar == HALT_ADDR);
    assign hit_budget  = (MAX_CYCLES != 32'd0) && (cycle_count == MAX_CYCLES - 32'd1);
    assign halt_clear  = (state == S_HALT) && clear;
    assign state_o     = state;

    assign cpu_mem_out = mem[cpu_mar[AW-1:0]];
    assign rd_data     = mem[rd_addr];

    // Clear has priority over start in HALT; start in IDLE needs an image already complete.
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:  if (start && loaded) next_state = S_RUN;
            S_RUN:   if (hit_halt || hit_budget) next_state = S_HALT;
            S_HALT: begin
                if (clear)      next_state = S_IDLE;
                else if (start) next_state = S_RUN;
            end
            default: next_state = S_IDLE;
        endcase
    end

    assign run_entry = (state != S_RUN) && (next_state == S_RUN);

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values; blocking here would create order-dependent simulation races.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= S_IDLE;
            cpu_reset   <= 1'b1;
            loaded      <= 1'b0;
            halted      <= 1'b0;
            timed_out   <= 1'b0;
            cycle_count <= 32'd0;
        end else begin
            state     <= next_state;
            cpu_reset <= (next_state != S_RUN);

            if (ld_fire)
                loaded <= ld_last;
            else if (halt_clear)
                loaded <= 1'b0;

            if (run_entry) begin
                cycle_count <= 32'd0;
                halted      <= 1'b0;
                timed_out   <= 1'b0;
            end else if (state == S_RUN) begin
                if (cycle_count != 32'hFFFF_FFFF)
                    cycle_count <= cycle_count + 32'd1;
                if (hit_halt)
                    halted <= 1'b1;
                else if (hit_budget)
                    timed_out <= 1'b1;
            end else if (halt_clear) begin
                halted    <= 1'b0;
                timed_out <= 1'b0;
            end
        end
    end

    // NOTE: the memory array has no reset; contents survive reset_n, which only
    // suppresses a write landing on an edge while reset is asserted.
    always_ff @(posedge clk) begin
        if (reset_n) begin
            if (ld_fire)
                mem[ld_addr] <= ld_data;
            else if ((state == S_RUN) && cpu_memwe)
                mem[cpu_mar[AW-1:0]] <= cpu_mdr;
        end
    end

endmodule

// File: tb/tb_lc3_boot_ctrl.sv
// Directed bench for lc3_boot_ctrl: load, start gating, halt, write wrap,
// timeout, restart, clear and asynchronous reset.
module tb_lc3_boot_ctrl;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        ld_valid;
    logic        ld_ready;
    logic [7:0]  ld_addr;
    logic [15:0] ld_data;
    logic        ld_last;
    logic        start;
    logic        clear;
    logic        cpu_reset;
    logic [15:0] cpu_mar;
    logic [15:0] cpu_mdr;
    logic        cpu_memwe;
    logic [15:0] cpu_mem_out;
    logic [7:0]  rd_addr;
    logic [15:0] rd_data;
    logic [1:0]  state_o;
    logic        loaded;
    logic        halted;
    logic        timed_out;
    logic [31:0] cycle_count;

    int n_vec = 0;
    int n_err = 0;

    lc3_boot_ctrl #(
        .AW        (8),
        .HALT_ADDR (16'h0025),
        .MAX_CYCLES(32'd20)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .ld_valid   (ld_valid),
        .ld_ready   (ld_ready),
        .ld_addr    (ld_addr),
        .ld_data    (ld_data),
        .ld_last    (ld_last),
        .start      (start),
        .clear      (clear),
        .cpu_reset  (cpu_reset),
        .cpu_mar    (cpu_mar),
        .cpu_mdr    (cpu_mdr),
        .cpu_memwe  (cpu_memwe),
        .cpu_mem_out(cpu_mem_out),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .state_o    (state_o),
        .loaded     (loaded),
        .halted     (halted),
        .timed_out  (timed_out),
        .cycle_count(cycle_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic peek(input logic [7:0] a, input string tag, input logic [15:0] exp);
        rd_addr = a;
        #1;
        check(tag, 32'(rd_data), 32'(exp));
    endtask

    initial begin
        reset_n   = 1'b0;
        ld_valid  = 1'b0;
        ld_addr   = 8'h00;
        ld_data   = 16'h0000;
        ld_last   = 1'b0;
        start     = 1'b0;
        clear     = 1'b0;
        cpu_mar   = 16'h0000;
        cpu_mdr   = 16'h0000;
        cpu_memwe = 1'b0;
        rd_addr   = 8'h00;

        // Reset state
        #12;
        check("rst_state",     32'(state_o),   32'd0);
        check("rst_cpu_reset", 32'(cpu_reset), 32'd1);
        check("rst_ld_ready",  32'(ld_ready),  32'd1);
        check("rst_loaded",    32'(loaded),    32'd0);
        check("rst_halted",    32'(halted),    32'd0);
        check("rst_timed_out", 32'(timed_out), 32'd0);
        check("rst_count",     cycle_count,    32'd0);
        reset_n = 1'b1;
        tick();

        // Load image; start coincident with last beat must be ignored
        ld_valid = 1'b1; ld_addr = 8'h00; ld_data = 16'h1021; ld_last = 1'b0;
        tick();
        check("ld0_ready",  32'(ld_ready), 32'd1);
        check("ld0_loaded", 32'(loaded),   32'd0);
        ld_addr = 8'h01; ld_data = 16'h5020;
        tick();
        check("ld1_ready",  32'(ld_ready), 32'd1);
        ld_addr = 8'h02; ld_data = 16'hF025; ld_last = 1'b1; start = 1'b1;
        tick();
        ld_valid = 1'b0; ld_last = 1'b0; start = 1'b0;
        check("ld2_loaded",    32'(loaded),    32'd1);
        check("gate_state",    32'(state_o),   32'd0);
        check("gate_cpu_rst",  32'(cpu_reset), 32'd1);
        check("ld2_ready",     32'(ld_ready),  32'd1);
        peek(8'h02, "mem2_load", 16'hF025);
        peek(8'h00, "mem0_load", 16'h1021);

        // Start -> RUN
        start = 1'b1;
        tick();
        start = 1'b0;
        check("run_state",    32'(state_o),   32'd1);
        check("run_cpu_rst",  32'(cpu_reset), 32'd0);
        check("run_ld_ready", 32'(ld_ready),  32'd0);
        check("run_count0",   cycle_count,    32'd0);

        cpu_mar = 16'h0003;
        tick();
        check("run_count1", cycle_count, 32'd1);
        cpu_mar = 16'h0010;
        tick();
        check("run_count2", cycle_count, 32'd2);

        // Core write with address wrap: 0x0140 -> mem[0x40]
        cpu_mar = 16'h0140; cpu_mdr = 16'hBEEF; cpu_memwe = 1'b1;
        tick();
        cpu_memwe = 1'b0;
        check("run_count3", cycle_count, 32'd3);
        #1;
        check("wrap_mem_out", 32'(cpu_mem_out), 32'h0000BEEF);
        peek(8'h40, "wrap_rd", 16'hBEEF);

        // Load port ignored in RUN
        cpu_mar = 16'h0010;
        ld_valid = 1'b1; ld_addr = 8'h00; ld_data = 16'hDEAD; ld_last = 1'b1;
        tick();
        ld_valid = 1'b0; ld_last = 1'b0;
        check("run_count4", cycle_count, 32'd4);
        peek(8'h00, "run_ld_ignored", 16'h1021);

        // Halt on RUN cycle 5
        cpu_mar = 16'h0025;
        tick();
        cpu_mar = 16'h0010;
        check("halt_state",   32'(state_o),   32'd2);
        check("halt_halted",  32'(halted),    32'd1);
        check("halt_timeout", 32'(timed_out), 32'd0);
        check("halt_count",   cycle_count,    32'd5);
        check("halt_cpu_rst", 32'(cpu_reset), 32'd1);
        check("halt_ready",   32'(ld_ready),  32'd0);

        // Core write ignored in HALT, count holds
        cpu_mar = 16'h0140; cpu_mdr = 16'h1111; cpu_memwe = 1'b1;
        tick();
        cpu_memwe = 1'b0; cpu_mar = 16'h0010;
        peek(8'h40, "halt_no_write", 16'hBEEF);
        check("halt_count_hold", cycle_count, 32'd5);

        // Restart from HALT, then run into timeout
        start = 1'b1;
        tick();
        start = 1'b0;
        check("restart_state",  32'(state_o), 32'd1);
        check("restart_count",  cycle_count,  32'd0);
        check("restart_halted", 32'(halted),  32'd0);
        for (int i = 0; i < 19; i++) tick();
        check("to_pre_state", 32'(state_o), 32'd1);
        check("to_pre_count", cycle_count,  32'd19);
        tick();
        check("to_state",   32'(state_o),   32'd2);
        check("to_flag",    32'(timed_out), 32'd1);
        check("to_halted",  32'(halted),    32'd0);
        check("to_count",   cycle_count,    32'd20);

        // Halt match on cycle 20 wins over budget; write in that cycle lands
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 19; i++) tick();
        cpu_mar = 16'h0025; cpu_mdr = 16'hABCD; cpu_memwe = 1'b1;
        tick();
        cpu_memwe = 1'b0; cpu_mar = 16'h0010;
        check("both_state",   32'(state_o),   32'd2);
        check("both_halted",  32'(halted),    32'd1);
        check("both_timeout", 32'(timed_out), 32'd0);
        check("both_count",   cycle_count,    32'd20);
        peek(8'h25, "halt_cycle_write", 16'hABCD);

        // clear + start together -> IDLE
        clear = 1'b1; start = 1'b1;
        tick();
        clear = 1'b0; start = 1'b0;
        check("clr_state",   32'(state_o),   32'd0);
        check("clr_loaded",  32'(loaded),    32'd0);
        check("clr_halted",  32'(halted),    32'd0);
        check("clr_count",   cycle_count,    32'd20);
        check("clr_cpu_rst", 32'(cpu_reset), 32'd1);

        // Start without an image is ignored
        start = 1'b1;
        tick();
        start = 1'b0;
        check("noimg_state", 32'(state_o), 32'd0);

        // Reload: complete image, partial beat clears loaded, complete again
        ld_valid = 1'b1; ld_addr = 8'h05; ld_data = 16'h7777; ld_last = 1'b1;
        tick();
        check("reld_loaded1", 32'(loaded), 32'd1);
        ld_addr = 8'h06; ld_data = 16'h6666; ld_last = 1'b0;
        tick();
        check("reld_partial", 32'(loaded), 32'd0);
        ld_addr = 8'h07; ld_data = 16'h8888; ld_last = 1'b1;
        tick();
        ld_valid = 1'b0; ld_last = 1'b0;
        check("reld_loaded2", 32'(loaded), 32'd1);

        // Run a few cycles, then async reset with an in-flight write
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        check("pre_rst_state", 32'(state_o), 32'd1);
        cpu_mar = 16'h0000; cpu_mdr = 16'h5555; cpu_memwe = 1'b1;
        reset_n = 1'b0;
        #1;
        check("arst_state",   32'(state_o),   32'd0);
        check("arst_cpu_rst", 32'(cpu_reset), 32'd1);
        check("arst_loaded",  32'(loaded),    32'd0);
        tick();
        cpu_memwe = 1'b0;
        peek(8'h00, "arst_write_dropped", 16'h1021);
        peek(8'h02, "arst_mem2", 16'hF025);
        peek(8'h07, "arst_mem7", 16'h8888);
        reset_n = 1'b1;
        tick();
        check("post_rst_state", 32'(state_o), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
